// File: rtl/nonce_reporter_if.sv
// Nonce-buffer reader side plus byte-wide host stream, bundled for nonce_reporter.
//   nonce_valid : buffer holds at least one unread nonce (buffer -> reporter)
//   nonce_data  : head-of-buffer nonce (buffer -> reporter)
//   nonce_rd    : pop strobe, combinational (reporter -> buffer)
//   tx_data     : outgoing byte (reporter -> sink)
//   tx_valid    : tx_data valid (reporter -> sink)
//   tx_ready    : sink accepts byte (sink -> reporter)
// master = reporter side, slave = buffer/sink side.
interface nonce_reporter_if;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned BYTE_W  = 8;

  logic               nonce_valid;
  logic [NONCE_W-1:0] nonce_data;
  logic               nonce_rd;
  logic [BYTE_W-1:0]  tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    input  nonce_valid, nonce_data, tx_ready,
    output nonce_rd, tx_data, tx_valid
  );

  modport slave (
    output nonce_valid, nonce_data, tx_ready,
    input  nonce_rd, tx_data, tx_valid
  );
endinterface

// File: rtl/nonce_reporter.sv
// Drains the nonce buffer and serializes each nonce as a 5-byte frame
// (HDR_BYTE + 4 bytes LSB first) on a valid/ready byte stream, then emits
// an end-of-run frame (END_BYTE + success byte) once the miner finishes.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bus_if (master)  : nonce buffer reader + byte stream
//   result_valid_i   : miner run complete (pulse or level)
//   success_i        : miner success flag, sampled with result_valid_i
//   busy_o           : frame in progress
//   report_count_o   : nonces fully transmitted, saturating
//   done_o           : end-of-run frame sent, held until rst
module nonce_reporter #(
  parameter int unsigned COUNT_W  = 16,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter logic [7:0]  END_BYTE = 8'h5A
) (
  input  logic               clk,
  input  logic               rst,
  nonce_reporter_if.master   bus_if,
  input  logic               result_valid_i,
  input  logic               success_i,
  output logic               busy_o,
  output logic [COUNT_W-1:0] report_count_o,
  output logic               done_o
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_B0, S_B1, S_B2, S_B3, S_EHDR, S_ESTAT, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NONCE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 pend_q, pend_d;
  logic                 succ_q, succ_d;
  logic                 xfer;
  logic                 nonce_rd_c;

  // Pop strobe is combinational so the head entry leaves on the capture edge.
  assign nonce_rd_c = !rst && (state_q == S_IDLE) && bus_if.nonce_valid;
  assign xfer       = tx_valid_q && bus_if.tx_ready;

  // Next-state, result latch and next registered outputs.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    pend_d     = pend_q;
    succ_d     = succ_q;
    tx_data_d  = '0;
    tx_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    // First completion wins; later assertions are ignored until reset.
    if (state_q != S_DONE && result_valid_i && !pend_q) begin
      pend_d = 1'b1;
      succ_d = success_i;
    end

    unique case (state_q)
      S_IDLE: begin
        // Queued nonces always drain before the end-of-run frame.
        if (nonce_rd_c) begin
          shift_d = bus_if.nonce_data;
          state_d = S_HDR;
        end else if (pend_q) begin
          state_d = S_EHDR;
        end
      end
      S_HDR: if (xfer) state_d = S_B0;
      S_B0: if (xfer) begin
        shift_d = {8'h00, shift_q[NONCE_W-1:BYTE_W]};
        state_d = S_B1;
      end
      S_B1: if (xfer) begin
        shift_d = {8'h00, shift_q[NONCE_W-1:BYTE_W]};
        state_d = S_B2;
      end
      S_B2: if (xfer) begin
        shift_d = {8'h00, shift_q[NONCE_W-1:BYTE_W]};
        state_d = S_B3;
      end
      S_B3: if (xfer) begin
        if (count_q != {COUNT_W{1'b1}}) count_d = count_q + COUNT_W'(1);
        state_d = S_IDLE;
      end
      S_EHDR:  if (xfer) state_d = S_ESTAT;
      S_ESTAT: if (xfer) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    unique case (state_d)
      S_HDR:                    tx_data_d = HDR_BYTE;
      S_B0, S_B1, S_B2, S_B3:   tx_data_d = shift_d[BYTE_W-1:0];
      S_EHDR:                   tx_data_d = END_BYTE;
      S_ESTAT:                  tx_data_d = {7'b0, succ_d};
      default:                  tx_data_d = '0;
    endcase
    tx_valid_d = (state_d != S_IDLE) && (state_d != S_DONE);
    busy_d     = tx_valid_d;
    done_d     = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      succ_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      succ_q     <= succ_d;
    end
  end

  assign bus_if.nonce_rd = nonce_rd_c;
  assign bus_if.tx_data  = tx_data_q;
  assign bus_if.tx_valid = tx_valid_q;
  assign busy_o          = busy_q;
  assign report_count_o  = count_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_nonce_reporter.sv
// Directed bench for nonce_reporter: frame format, backpressure, end-of-run,
// mid-frame reset and counter saturation (second instance with COUNT_W=2).
module tb_nonce_reporter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nonce_reporter_if ifa ();
  nonce_reporter_if ifb ();

  logic        rv_a, succ_a, busy_a, done_a;
  logic [15:0] cnt_a;
  logic        rv_b, succ_b, busy_b, done_b;
  logic [1:0]  cnt_b;

  nonce_reporter #(.COUNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus_if(ifa),
    .result_valid_i(rv_a), .success_i(succ_a),
    .busy_o(busy_a), .report_count_o(cnt_a), .done_o(done_a)
  );

  nonce_reporter #(.COUNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus_if(ifb),
    .result_valid_i(rv_b), .success_i(succ_b),
    .busy_o(busy_b), .report_count_o(cnt_b), .done_o(done_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buffer model for instance A.
  logic [31:0] buf_q[$];
  always @(posedge clk) if (ifa.nonce_rd) void'(buf_q.pop_front());

  task automatic upd_buf();
    ifa.nonce_valid = (buf_q.size() != 0);
    ifa.nonce_data  = (buf_q.size() != 0) ? buf_q[0] : 32'h0;
  endtask

  // Stream monitor for instance A: collects transfers and checks holding.
  int          cyc = 0;
  logic [7:0]  got_q[$];
  int          stamp_q[$];
  logic        held = 1'b0;
  logic [7:0]  held_byte = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (held) begin
        chk("hold_valid", 32'(ifa.tx_valid), 32'd1);
        chk("hold_data", 32'(ifa.tx_data), 32'(held_byte));
      end
      if (ifa.tx_valid && ifa.tx_ready) begin
        got_q.push_back(ifa.tx_data);
        stamp_q.push_back(cyc);
      end
    end
    held      <= !rst && ifa.tx_valid && !ifa.tx_ready;
    held_byte <= ifa.tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    upd_buf();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    buf_q.delete();
    upd_buf();
    got_q.delete();
    stamp_q.delete();
  endtask

  task automatic chk_stream(input string tag, input logic [7:0] exp[$]);
    chk($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got_q.size())
        chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp[i]));
  endtask

  task automatic run_until_done(input int max_cyc);
    for (int i = 0; i < max_cyc && !done_a; i++) tick();
    chk("done_timeout", 32'(done_a), 32'd1);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] seq1[5];
  logic [1:0] sat_exp[5];
  logic [3:0] rdy_pat;

  initial begin
    ifa.tx_ready = 1'b1; ifa.nonce_valid = 1'b0; ifa.nonce_data = '0;
    ifb.tx_ready = 1'b1; ifb.nonce_valid = 1'b0; ifb.nonce_data = '0;
    rv_a = 1'b0; succ_a = 1'b0; rv_b = 1'b0; succ_b = 1'b0;

    // Reset values; pop strobe suppressed while rst=1.
    rst = 1'b1;
    tick();
    ifa.nonce_valid = 1'b1;
    #1;
    chk("rst_nonce_rd", 32'(ifa.nonce_rd), 32'd0);
    tick();
    chk("rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(ifa.tx_data), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    do_reset();

    // Single nonce, tx_ready=1.
    seq1 = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
    buf_q.push_back(32'h12345678);
    upd_buf();
    #1;
    chk("t1_nonce_rd", 32'(ifa.nonce_rd), 32'd1);
    tick();
    #1;
    chk("t1_nonce_rd_off", 32'(ifa.nonce_rd), 32'd0);
    chk("t1_busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_valid%0d", i), 32'(ifa.tx_valid), 32'd1);
      chk($sformatf("t1_data%0d", i), 32'(ifa.tx_data), 32'(seq1[i]));
      tick();
    end
    chk("t1_gap_valid", 32'(ifa.tx_valid), 32'd0);
    chk("t1_busy_off", 32'(busy_a), 32'd0);
    chk("t1_count", 32'(cnt_a), 32'd1);
    exp_q = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
    chk_stream("t1_stream", exp_q);

    // Backpressure with ready pattern 1,0,0,1.
    got_q.delete();
    rdy_pat = 4'b1001;
    buf_q.push_back(32'h12345678);
    upd_buf();
    for (int i = 0; i < 60 && cnt_a != 16'd2; i++) begin
      ifa.tx_ready = rdy_pat[i % 4];
      tick();
    end
    ifa.tx_ready = 1'b1;
    chk("t2_count", 32'(cnt_a), 32'd2);
    chk_stream("t2_stream", exp_q);

    // Two queued nonces, result during first frame, then end frame.
    do_reset();
    buf_q.push_back(32'h11223344);
    buf_q.push_back(32'hAABBCCDD);
    upd_buf();
    tick();
    tick();
    rv_a = 1'b1; succ_a = 1'b1;
    tick();
    rv_a = 1'b0; succ_a = 1'b0;
    run_until_done(60);
    exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11,
              8'hA5, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h5A, 8'h01};
    chk_stream("t3_stream", exp_q);
    if (stamp_q.size() >= 6)
      chk("t3_gap", 32'(stamp_q[5] - stamp_q[4]), 32'd2);
    chk("t3_count", 32'(cnt_a), 32'd2);
    chk("t3_tx_valid", 32'(ifa.tx_valid), 32'd0);
    chk("t3_busy", 32'(busy_a), 32'd0);

    // Failure result with empty buffer; DONE leaves later nonces queued.
    do_reset();
    rv_a = 1'b1; succ_a = 1'b0;
    tick();
    rv_a = 1'b0;
    run_until_done(20);
    exp_q = '{8'h5A, 8'h00};
    chk_stream("t4_stream", exp_q);
    buf_q.push_back(32'hCAFEF00D);
    upd_buf();
    #1;
    chk("t4_no_pop", 32'(ifa.nonce_rd), 32'd0);
    rv_a = 1'b1; succ_a = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rv_a = 1'b0; succ_a = 1'b0;
    chk("t4_buf_kept", 32'(buf_q.size()), 32'd1);
    chk("t4_done_held", 32'(done_a), 32'd1);
    chk("t4_tx_idle", 32'(ifa.tx_valid), 32'd0);
    chk("t4_stream_len", 32'(got_q.size()), 32'd2);

    // Reset during B1, then a fresh frame.
    do_reset();
    buf_q.push_back(32'h12345678);
    upd_buf();
    tick();
    tick();
    tick();
    chk("t5_in_b1", 32'(ifa.tx_data), 32'h56);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(ifa.tx_valid), 32'd0);
    chk("t5_rst_count", 32'(cnt_a), 32'd0);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    got_q.delete();
    tick();
    tick();
    chk("t5_no_resume", 32'(ifa.tx_valid), 32'd0);
    buf_q.push_back(32'hDEADBEEF);
    upd_buf();
    for (int i = 0; i < 20 && cnt_a != 16'd1; i++) tick();
    exp_q = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk_stream("t5_stream", exp_q);
    chk("t5_count", 32'(cnt_a), 32'd1);

    // Saturation on the 2-bit counter instance.
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      ifb.nonce_valid = 1'b1;
      ifb.nonce_data  = 32'(k);
      tick();
      ifb.nonce_valid = 1'b0;
      for (int j = 0; j < 5; j++) tick();
      chk($sformatf("t6_count%0d", k), 32'(cnt_b), 32'(sat_exp[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/nonce_reporter.md
Name: nonce_reporter

Overview:
- Drains the nonce buffer from its reader side and serializes each found nonce onto a byte-wide valid/ready stream toward the host link.
- Once the miner signals completion through resultValid/success, it appends an end-of-run frame carrying the success flag.
- Sits in top alongside bcminer, consuming the nonce buffer that bcminer writes.

Parameters:
COUNT_W, 16, width of the saturating reported-nonce counter
HDR_BYTE, 8'hA5, frame header byte preceding each nonce
END_BYTE, 8'h5A, frame header byte preceding the end-of-run status byte

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
nonce_valid  input  1  nonce buffer holds at least one unread nonce
nonce_data  input  32  head-of-buffer nonce; valid while nonce_valid=1
nonce_rd  output  1  pop strobe; head entry consumed on the edge where nonce_rd=1
result_valid  input  1  miner run complete; pulse or level
success  input  1  miner success flag, sampled with result_valid
tx_data  output  8  outgoing byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  sink accepts the byte; transfer when tx_valid && tx_ready at an edge
busy  output  1  frame in progress (state not IDLE or DONE)
report_count  output  COUNT_W  nonces fully transmitted, saturating at all-ones
done  output  1  end-of-run frame fully sent; held until rst

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; tx_valid=0, tx_data=0, report_count=0, done=0, busy=0; pending-result flag and stored success cleared. nonce_rd=0 while rst=1. Reset mid-frame abandons the frame; no bytes resume after reset.
- States: IDLE, HDR, B0, B1, B2, B3, EHDR, ESTAT, DONE.
- nonce_rd is combinational: nonce_rd = !rst && state==IDLE && nonce_valid.
- IDLE, nonce pop:
  - If nonce_rd=1, capture nonce_data into a 32-bit shift register on that edge and go to HDR.
  - tx_valid rises the next cycle, so latency is nonce_valid -> first tx_valid = 1 cycle.
- IDLE, end-of-run: if nonce_valid=0 and the pending flag is set, go to EHDR. Queued nonces always drain before the end frame.
- Result latch, in any state except DONE:
  - result_valid=1 while the pending flag is clear sets the flag and stores success.
  - Later result_valid assertions are ignored until rst.
  - result_valid arriving in the same cycle as a pop sets the flag; the nonce is still popped first.
- Byte output:
  - HDR outputs HDR_BYTE.
  - B0..B3 output nonce bytes LSB first: B0=[7:0], B1=[15:8], B2=[23:16], B3=[31:24].
  - EHDR outputs END_BYTE.
  - ESTAT outputs {7'b0, stored success}.
- Handshake:
  - In a sending state, tx_valid=1 and tx_data is registered and stable until the transfer edge.
  - Advance to the next state only on tx_valid && tx_ready.
  - tx_valid never drops without a transfer except on rst.
  - tx_ready asserted in a non-sending state has no effect.
- Back-to-back frames: after the B3 transfer, return to IDLE. One IDLE cycle separates frames (tx_valid=0 in IDLE).
- report_count increments on the B3 transfer edge and saturates at 2^COUNT_W-1, with no wrap.
- ESTAT transfer -> DONE:
  - done=1 from the next cycle; tx_valid=0.
  - nonce_rd stays 0 even if nonce_valid=1; entries are left in the buffer.
  - Only rst exits DONE.
- busy=1 in HDR, B0..B3, EHDR and ESTAT; 0 otherwise.

Test Plan:
- Single nonce, tx_ready=1: nonce_data=32'h12345678, nonce_valid for 1 pop -> nonce_rd pulses 1 cycle; stream A5,78,56,34,12 on consecutive cycles; report_count=1.
- Backpressure: same nonce with tx_ready toggling 1,0,0,1,... -> each byte is held stable with tx_valid=1 until accepted; byte order unchanged; no duplicate or lost bytes.
- Two queued nonces plus result_valid=1, success=1 asserted during the first frame -> A5+4 bytes, one-cycle gap, A5+4 bytes, then 5A,01; done=1; report_count=2.
- result_valid=1, success=0 with empty buffer -> 5A,00; done=1; a later nonce_valid=1 produces no nonce_rd.
- rst asserted during B1 -> next cycle tx_valid=0, report_count=0, state IDLE; a subsequent nonce 32'hDEADBEEF yields A5,EF,BE,AD,DE.
- Counter saturation with COUNT_W=2: send 5 nonces -> report_count reads 1,2,3,3,3.
